// File: rtl/div_ratio_ctrl.sv
// Run-time controller for a programmable clock divider: exact-period divided clock with a
// round-robin arbitrated ratio update that takes effect only at a period boundary.
module div_ratio_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEF_N = 10
) (
  input  logic         clk,
  input  logic         r,
  input  logic         en,
  input  logic         req_a,
  input  logic [W-1:0] n_a,
  input  logic         req_b,
  input  logic [W-1:0] n_b,
  output logic         gnt_a,
  output logic         gnt_b,
  output logic         err,
  output logic         busy,
  output logic         o,
  output logic         tick,
  output logic [W-1:0] cur_n
);

  typedef enum logic [1:0] {StIdle, StHi, StLo} state_e;

  state_e       state;
  logic [W-1:0] cnt;
  logic [W-1:0] pend;
  logic         last_b;

  logic [W:0]   hi_len;
  logic [W-1:0] lo_len;
  logic         hi_end;
  logic         lo_end;
  logic         eligible;
  logic         win_a;
  logic         win_b;
  logic [W-1:0] win_n;
  logic         apply;

  // One extra bit so ceil(cur_n/2) cannot overflow at cur_n = 2^W-1.
  always_comb begin
    hi_len   = ({1'b0, cur_n} + (W+1)'(1)) >> 1;
    lo_len   = cur_n >> 1;
    hi_end   = ({1'b0, cnt} == (hi_len - (W+1)'(1)));
    lo_end   = (cnt == (lo_len - W'(1)));
    // A grant last cycle blocks arbitration so the requester can drop req.
    eligible = !busy && !gnt_a && !gnt_b;
    win_a    = req_a && (!req_b || last_b);
    win_b    = req_b && !win_a;
    win_n    = win_a ? n_a : n_b;
    apply    = busy && ((state == StIdle) || (en && (state == StLo) && lo_end));
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state  <= StIdle;
      cnt    <= '0;
      o      <= 1'b0;
      tick   <= 1'b0;
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      pend   <= '0;
      cur_n  <= W'(DEF_N);
      last_b <= 1'b1;
    end else begin
      tick  <= 1'b0;
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      err   <= 1'b0;

      if (!en) begin
        state <= StIdle;
        o     <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          StIdle: begin
            state <= StHi;
            o     <= 1'b1;
            tick  <= 1'b1;
            cnt   <= '0;
          end
          StHi: begin
            if (hi_end) begin
              state <= StLo;
              o     <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + W'(1);
            end
          end
          StLo: begin
            if (lo_end) begin
              state <= StHi;
              o     <= 1'b1;
              tick  <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + W'(1);
            end
          end
          default: begin
            state <= StIdle;
            o     <= 1'b0;
            cnt   <= '0;
          end
        endcase
      end

      // apply needs busy=1 and a grant needs busy=0, so they never collide.
      if (apply) begin
        cur_n <= pend;
        busy  <= 1'b0;
      end

      if (eligible && (win_a || win_b)) begin
        gnt_a <= win_a;
        gnt_b <= win_b;
        // The pointer only moves when a tie is resolved.
        if (req_a && req_b) last_b <= win_b;
        if (win_n >= W'(2)) begin
          pend <= win_n;
          busy <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_ratio_ctrl.sv
// Directed self-checking bench for div_ratio_ctrl: period shape, arbitration, apply timing,
// rejected ratios, enable drop and asynchronous reset.
module tb_div_ratio_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         r;
  logic         en;
  logic         req_a;
  logic [W-1:0] n_a;
  logic         req_b;
  logic [W-1:0] n_b;
  logic         gnt_a;
  logic         gnt_b;
  logic         err;
  logic         busy;
  logic         o;
  logic         tick;
  logic [W-1:0] cur_n;

  int n_chk  = 0;
  int n_pass = 0;
  int gnt_b_n = 0;
  int hi;
  int lo;

  div_ratio_ctrl #(
    .W    (W),
    .DEF_N(10)
  ) dut (
    .clk  (clk),
    .r    (r),
    .en   (en),
    .req_a(req_a),
    .n_a  (n_a),
    .req_b(req_b),
    .n_b  (n_b),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b),
    .err  (err),
    .busy (busy),
    .o    (o),
    .tick (tick),
    .cur_n(cur_n)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (gnt_b === 1'b1) gnt_b_n++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts high/low cycles from the current cycle up to (not including) the next tick cycle.
  task automatic run_to_tick(output int h, output int l);
    bit done;
    h    = 0;
    l    = 0;
    done = 1'b0;
    for (int i = 0; i < 600 && !done; i++) begin
      if (o) h++;
      else l++;
      step();
      if (tick) done = 1'b1;
    end
    if (!done) check("tick_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    r = 1'b1; en = 1'b0; req_a = 1'b0; n_a = '0; req_b = 1'b0; n_b = '0;
    step();
    step();
    check("rst_o", o, 0);
    check("rst_tick", tick, 0);
    check("rst_gnt", {gnt_a, gnt_b, err}, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_n", cur_n, 10);
    r = 1'b0;
    step();
    check("idle_o", o, 0);

    // Default ratio 10: 5 high / 5 low.
    en = 1'b1;
    step();
    check("first_tick", tick, 1);
    check("first_o", o, 1);
    run_to_tick(hi, lo);
    check("p10_hi", hi, 5);
    check("p10_lo", lo, 5);
    run_to_tick(hi, lo);
    check("p10b_hi", hi, 5);
    check("p10b_lo", lo, 5);

    // Load 7 mid-HI; current period must finish unchanged.
    step();
    step();
    req_a = 1'b1; n_a = 8'd7;
    step();
    check("a7_gnt", gnt_a, 1);
    check("a7_busy", busy, 1);
    req_a = 1'b0;
    run_to_tick(hi, lo);
    check("a7_rest_hi", hi, 2);
    check("a7_rest_lo", lo, 5);
    check("a7_cur_n", cur_n, 7);
    check("a7_busy_clr", busy, 0);
    run_to_tick(hi, lo);
    check("p7_hi", hi, 4);
    check("p7_lo", lo, 3);

    // Tie after reset: A first, B once busy falls.
    r = 1'b1; en = 1'b0;
    step();
    r = 1'b0; en = 1'b1;
    req_a = 1'b1; n_a = 8'd4; req_b = 1'b1; n_b = 8'd6;
    step();
    check("tie1_gnt", {gnt_a, gnt_b}, 2'b10);
    check("tie1_tick", tick, 1);
    check("tie1_cur_n", cur_n, 10);
    req_a = 1'b0;
    gnt_b_n = 0;
    run_to_tick(hi, lo);
    check("tie1_hi", hi, 5);
    check("tie1_lo", lo, 5);
    check("tie1_b_wait", gnt_b_n, 0);
    check("tie1_cur_n4", cur_n, 4);
    step();
    check("tie1_gnt_b", {gnt_a, gnt_b}, 2'b01);
    check("tie1_busy_b", busy, 1);
    req_b = 1'b0;
    run_to_tick(hi, lo);
    check("p4_rest_hi", hi, 1);
    check("p4_rest_lo", lo, 2);
    check("tie1_cur_n6", cur_n, 6);
    run_to_tick(hi, lo);
    check("p6_hi", hi, 3);
    check("p6_lo", lo, 3);

    // Second tie: A won the last tie, so B wins now.
    req_a = 1'b1; n_a = 8'd4; req_b = 1'b1; n_b = 8'd6;
    step();
    check("tie2_gnt", {gnt_a, gnt_b}, 2'b01);
    req_a = 1'b0; req_b = 1'b0;
    run_to_tick(hi, lo);
    check("tie2_cur_n", cur_n, 6);
    check("tie2_busy", busy, 0);

    // Ratio 1 is rejected.
    req_b = 1'b1; n_b = 8'd1;
    step();
    check("err_gnt_b", gnt_b, 1);
    check("err_pulse", err, 1);
    check("err_busy", busy, 0);
    req_b = 1'b0;
    step();
    check("err_clear", err, 0);
    run_to_tick(hi, lo);
    check("err_rest_hi", hi, 1);
    check("err_rest_lo", lo, 3);
    check("err_cur_n", cur_n, 6);
    run_to_tick(hi, lo);
    check("err_p_hi", hi, 3);
    check("err_p_lo", lo, 3);

    // Enable dropped mid-LO with 12 pending: applies from IDLE.
    req_a = 1'b1; n_a = 8'd12;
    step();
    check("e12_gnt", gnt_a, 1);
    req_a = 1'b0;
    step();
    step();
    step();
    check("e12_in_lo", o, 0);
    en = 1'b0;
    step();
    check("e12_idle_o", o, 0);
    check("e12_cur_old", cur_n, 6);
    check("e12_busy", busy, 1);
    step();
    check("e12_cur_new", cur_n, 12);
    check("e12_busy_clr", busy, 0);
    en = 1'b1;
    step();
    check("e12_tick", tick, 1);
    run_to_tick(hi, lo);
    check("p12_hi", hi, 6);
    check("p12_lo", lo, 6);

    // Async reset while busy mid-HI.
    req_a = 1'b1; n_a = 8'd5;
    step();
    check("r5_busy", busy, 1);
    req_a = 1'b0;
    step();
    r = 1'b1;
    #1;
    check("r5_o", o, 0);
    check("r5_busy_clr", busy, 0);
    check("r5_cur_n", cur_n, 10);
    step();
    r = 1'b0;
    step();
    check("r5_tick", tick, 1);
    run_to_tick(hi, lo);
    check("r5_hi", hi, 5);
    check("r5_lo", lo, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/div_ratio_ctrl.md
Name: div_ratio_ctrl

Overview:
- Run-time controller for the programmable clock divider.
- Produces a divided output `o` with an exact period of `cur_n` cycles, plus a one-cycle `tick` at each rising edge of `o`.
- Two requesters (A, B) share the right to reprogram the divide ratio through a round-robin arbiter with a req/gnt handshake.
- A new ratio takes effect only at a period boundary, so `o` never glitches or produces a short phase.

Parameters:
- W, 8, width of divide ratio, counter and `cur_n`.
- DEF_N, 10, divide ratio loaded at reset (must be ≥ 2).

Ports:
- clk  in  1  system clock, all state on posedge.
- r  in  1  reset.
- en  in  1  divider run enable.
- req_a  in  1  requester A wants to load `n_a`; level, held until `gnt_a`.
- n_a  in  W  ratio from A; stable while `req_a` is 1.
- req_b  in  1  requester B wants to load `n_b`; level, held until `gnt_b`.
- n_b  in  W  ratio from B; stable while `req_b` is 1.
- gnt_a  out  1  one-cycle grant pulse to A.
- gnt_b  out  1  one-cycle grant pulse to B.
- err  out  1  one-cycle pulse, coincident with the grant, when the granted ratio is < 2 (rejected).
- busy  out  1  accepted ratio pending, not yet applied.
- o  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse in the first cycle of each high phase.
- cur_n  out  W  ratio currently in effect.

Behaviour:
- One clock; reset is asynchronous and active-high (`clk`, `r`).
- Reset state:
  - o=0, tick=0, gnt_a=0, gnt_b=0, err=0, busy=0.
  - cur_n=DEF_N, counter=0, FSM=IDLE.
  - Round-robin pointer set to "B last served", so A wins the first tie.
- Phase lengths, from `cur_n`:
  - hi_len = ceil(cur_n/2), lo_len = floor(cur_n/2).
  - Period = cur_n cycles exactly, for both odd and even ratios.
- FSM:
  - IDLE (o=0, counter=0): on en=1, next cycle → HI with o=1, tick=1, counter=0.
  - HI: counter increments each cycle. When counter == hi_len-1, next cycle → LO with o=0, counter=0.
  - LO: counter increments each cycle. When counter == lo_len-1 (period boundary), next cycle → HI with o=1, tick=1, counter=0. If busy, at this same edge cur_n ← pending ratio and busy ← 0; the new HI phase uses the new ratio.
  - Any state with en=0: next cycle → IDLE, o=0, counter=0. Partial period is abandoned; no tick.
- Ratio apply in IDLE: if busy, cur_n ← pending and busy ← 0 on the next edge. No boundary wait.
- Arbitration, evaluated each edge:
  - Eligible only when busy=0 and no grant was issued in the previous cycle. The previous-cycle rule gives the requester one cycle to drop req.
  - Only one requesting: it wins.
  - Both requesting: the one not served last wins, then the pointer updates.
  - Winner gets a gnt pulse the next cycle.
  - Ratio ≥ 2: latched into the pending register, busy=1 from the grant cycle on.
  - Ratio < 2: err=1 with the grant; nothing latched; busy stays 0; cur_n unchanged.
- While busy=1, requests wait; no grant is issued.
- Simultaneous events:
  - Grant captured on the same edge as a period boundary (busy was 0): the value applies at the next boundary, not this one.
  - Apply and new grant can never coincide (busy blocks grants).
- Reset mid-operation: immediate return to reset state.
  - Pending ratio is discarded; cur_n=DEF_N.
  - Outstanding reqs are re-arbitrated after reset is released.
- Width: counter is W bits; cur_n max 2^W-1; no arithmetic overflow is possible.

Test Plan:
- Reset release, en=1, DEF_N=10: o high 5 / low 5. Tick every 10 cycles; first tick 1 cycle after en sampled. cur_n=10.
- req_a with n_a=7 asserted mid-HI:
  - gnt_a pulses 1 cycle after req_a is sampled; busy=1.
  - Current 10-cycle period completes unchanged.
  - Next period: high 4, low 3; cur_n=7; busy=0.
- req_a (n_a=4) and req_b (n_b=6) asserted in the same cycle after reset, both held until granted:
  - gnt_a first; 4 applied at the next boundary.
  - gnt_b issued only after busy falls; 6 applied at the following boundary.
  - Repeat the tie: gnt_b wins.
- req_b with n_b=1: gnt_b and err pulse together; busy stays 0; cur_n and period unchanged.
- en dropped mid-LO with busy=1 (pending 12):
  - o=0 next cycle, IDLE; cur_n=12 one cycle later.
  - On re-enable: high 6 / low 6, first tick 1 cycle after en.
- r pulsed while busy=1 mid-HI: o=0, busy=0, cur_n=10 immediately. After release with en=1, period is 10.
